// File: rtl/rst_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : rst_ctrl_if
//  Description : Board-side signal bundle of the system reset controller.
//                The board and the testbench drive through the master
//                modport. The controller uses the slave modport.
//  Revision    : 1.0 - initial release
// ============================================================================
interface rst_ctrl_if #(
    parameter int CNT_WIDTH = 24
);
    logic                 key_n;      // raw pushbutton, active-low, asynchronous
    logic                 sw_rst;     // software reset request
    logic                 wdt_en;     // watchdog enable level
    logic                 wdt_kick;   // watchdog restart pulse
    logic                 sys_rst_n;  // registered active-low system reset
    logic [2:0]           cause;      // {wdt, sw, key}; 3'b000 = power-on
    logic [CNT_WIDTH-1:0] uptime;     // cycles spent in RUN since the last reset

    modport master (
        output key_n, sw_rst, wdt_en, wdt_kick,
        input  sys_rst_n, cause, uptime
    );

    modport slave (
        input  key_n, sw_rst, wdt_en, wdt_kick,
        output sys_rst_n, cause, uptime
    );
endinterface
`default_nettype wire

// File: rtl/rst_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : rst_ctrl
//  Description : System reset controller. Combines the power-on reset, a
//                debounced pushbutton, a software request and a watchdog into
//                sys_rst_n. The release is synchronous and stretched. The
//                block also records the last reset cause and counts uptime.
//  Revision    : 1.0 - initial release
// ============================================================================
module rst_ctrl #(
    parameter int SYNC_STAGES     = 3,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int HOLD_CYCLES     = 16,
    parameter int WDT_WIDTH       = 24,
    parameter int CNT_WIDTH       = 24
) (
    input  wire logic   clk,
    input  wire logic   rst_n,
    rst_ctrl_if.slave   bus
);

    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);

    localparam logic [DB_W-1:0]   c_db_last   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] c_hold_last = HOLD_W'(HOLD_CYCLES - 1);

    typedef enum logic [0:0] {
        HOLD = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Key conditioning
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   key_stable_q;
    logic [DB_W-1:0]        db_cnt_q;
    logic                   w_key_sync;

    // Reset sequencer
    state_t                 state_q,     state_d;
    logic [HOLD_W-1:0]      hold_cnt_q,  hold_cnt_d;
    logic [WDT_WIDTH-1:0]   wdt_cnt_q,   wdt_cnt_d;
    logic [CNT_WIDTH-1:0]   uptime_q,    uptime_d;
    logic [2:0]             cause_q,     cause_d;
    logic                   sys_rst_n_q, sys_rst_n_d;

    logic                   w_wdt_to;
    logic [2:0]             w_trig;

    assign w_key_sync = sync_q[SYNC_STAGES-1];

    // Synchronise the raw button and accept a new level only after it has
    // differed from the accepted level for DEBOUNCE_CYCLES consecutive edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q       <= '1;
            key_stable_q <= 1'b1;
            db_cnt_q     <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], bus.key_n};
            if (w_key_sync == key_stable_q) begin
                db_cnt_q <= '0;
            end else if (db_cnt_q == c_db_last) begin
                key_stable_q <= w_key_sync;
                db_cnt_q     <= '0;
            end else begin
                db_cnt_q <= db_cnt_q + DB_W'(1);
            end
        end
    end

    // A kick on the expiry cycle takes priority over the timeout.
    assign w_wdt_to = bus.wdt_en & ~bus.wdt_kick & (&wdt_cnt_q);
    assign w_trig   = {w_wdt_to, bus.sw_rst, ~key_stable_q};

    // Sequencer registers. The async clear forces sys_rst_n low with no clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= HOLD;
            hold_cnt_q  <= '0;
            wdt_cnt_q   <= '0;
            uptime_q    <= '0;
            cause_q     <= 3'b000;
            sys_rst_n_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_cnt_q  <= hold_cnt_d;
            wdt_cnt_q   <= wdt_cnt_d;
            uptime_q    <= uptime_d;
            cause_q     <= cause_d;
            sys_rst_n_q <= sys_rst_n_d;
        end
    end

    // Next state. A held button keeps HOLD from timing out. sys_rst_n is
    // taken from the next state, so it changes on the same edge as the state.
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        wdt_cnt_d  = '0;
        uptime_d   = uptime_q;
        cause_d    = cause_q;

        case (state_q)
            HOLD: begin
                uptime_d = '0;
                if (!key_stable_q) begin
                    hold_cnt_d = '0;
                end else if (hold_cnt_q == c_hold_last) begin
                    hold_cnt_d = '0;
                    state_d    = RUN;
                end else begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
            end
            RUN: begin
                hold_cnt_d = '0;
                if (|w_trig) begin
                    state_d  = HOLD;
                    cause_d  = w_trig;
                    uptime_d = '0;
                end else begin
                    uptime_d = uptime_q + CNT_WIDTH'(1);
                    if (bus.wdt_en && !bus.wdt_kick) begin
                        wdt_cnt_d = wdt_cnt_q + WDT_WIDTH'(1);
                    end
                end
            end
            default: begin
                state_d    = HOLD;
                hold_cnt_d = '0;
            end
        endcase

        sys_rst_n_d = (state_d == RUN);
    end

    assign bus.sys_rst_n = sys_rst_n_q;
    assign bus.cause     = cause_q;
    assign bus.uptime    = uptime_q;

endmodule
`default_nettype wire

// File: tb/tb_rst_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rst_ctrl
//  Description : Self-checking bench for rst_ctrl. A timestamp-based reference
//                model is updated on every clock edge. It tracks edge numbers
//                for the RUN entry, the hold start and the last watchdog
//                restart.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rst_ctrl;

    localparam int SYNC = 2;
    localparam int DEB  = 4;
    localparam int HOLD = 5;
    localparam int WDTW = 4;
    localparam int CNTW = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int checks   = 0;
    int failures = 0;

    rst_ctrl_if #(.CNT_WIDTH(CNTW)) bus ();

    rst_ctrl #(
        .SYNC_STAGES     (SYNC),
        .DEBOUNCE_CYCLES (DEB),
        .HOLD_CYCLES     (HOLD),
        .WDT_WIDTH       (WDTW),
        .CNT_WIDTH       (CNTW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int         n;            // edges since rst_n release
    logic       m_sync [SYNC];
    logic       m_stable;
    int         m_mis;        // consecutive edges key_sync differed from m_stable
    bit         m_run;
    logic [2:0] m_cause;
    int         m_run_start;  // edge that entered RUN
    int         m_hold_from;  // edge after which the hold count was zero
    int         m_wdt_zero;   // edge after which the watchdog count was zero

    task automatic model_reset();
        n = 0;
        for (int i = 0; i < SYNC; i++) m_sync[i] = 1'b1;
        m_stable    = 1'b1;
        m_mis       = 0;
        m_run       = 1'b0;
        m_cause     = 3'b000;
        m_run_start = 0;
        m_hold_from = 0;
        m_wdt_zero  = 0;
    endtask

    // Call this right after a posedge. The inputs still hold their pre-edge values.
    task automatic model_edge();
        logic       ks;
        logic       sp;
        logic       wto;
        logic [2:0] trig;
        int         wval;
        n++;
        ks = m_stable;
        sp = m_sync[SYNC-1];
        if (m_run) begin
            wval = (n - 1) - m_wdt_zero;
            wto  = bus.wdt_en && !bus.wdt_kick && (wval == (1 << WDTW) - 1);
            trig = {wto, bus.sw_rst, ~ks};
            if (trig != 3'b000) begin
                m_run       = 1'b0;
                m_cause     = trig;
                m_hold_from = n;
            end else if (!bus.wdt_en || bus.wdt_kick) begin
                m_wdt_zero = n;
            end
        end else begin
            if (!ks) begin
                m_hold_from = n;
            end else if (n - m_hold_from == HOLD) begin
                m_run       = 1'b1;
                m_run_start = n;
                m_wdt_zero  = n;
            end
        end
        if (sp != m_stable) begin
            m_mis++;
            if (m_mis == DEB) begin
                m_stable = sp;
                m_mis    = 0;
            end
        end else begin
            m_mis = 0;
        end
        for (int i = SYNC - 1; i > 0; i--) m_sync[i] = m_sync[i-1];
        m_sync[0] = bus.key_n;
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        logic [CNTW-1:0] up_exp;
        up_exp = m_run ? CNTW'(n - m_run_start) : '0;
        chk({tag, "_sys_rst_n"}, 32'(bus.sys_rst_n), 32'(m_run));
        chk({tag, "_cause"},     32'(bus.cause),     32'(m_cause));
        chk({tag, "_uptime"},    32'(bus.uptime),    32'(up_exp));
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_model(tag);
    endtask

    // Pulse rst_n low in mid-cycle and check that the outputs clear before the next edge.
    task automatic apply_reset();
        @(posedge clk);
        #2;
        rst_n        = 1'b0;
        bus.key_n    = 1'b1;
        bus.sw_rst   = 1'b0;
        bus.wdt_en   = 1'b0;
        bus.wdt_kick = 1'b0;
        #1;
        chk("async_sys_rst_n", 32'(bus.sys_rst_n), 32'd0);
        chk("async_cause",     32'(bus.cause),     32'd0);
        chk("async_uptime",    32'(bus.uptime),    32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bus.key_n    = 1'b1;
        bus.sw_rst   = 1'b0;
        bus.wdt_en   = 1'b0;
        bus.wdt_kick = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_model("por_in_reset");
        rst_n = 1'b1;

        // 1. Power-on release: rises after edge 5, uptime 3 after three more edges.
        for (int i = 1; i <= 8; i++) begin
            tick("por");
            if (i == 4) chk("por_low_edge4", 32'(bus.sys_rst_n), 32'd0);
            if (i == 5) chk("por_high_edge5", 32'(bus.sys_rst_n), 32'd1);
        end
        chk("por_uptime3", 32'(bus.uptime), 32'd3);
        apply_reset();

        // 2. Software reset, plus a request during HOLD that must be ignored.
        repeat (7) tick("sw_pre");
        bus.sw_rst = 1'b1;
        tick("sw_edge");
        bus.sw_rst = 1'b0;
        chk("sw_cause", 32'(bus.cause), 32'h2);
        chk("sw_low",   32'(bus.sys_rst_n), 32'd0);
        repeat (2) tick("sw_hold");
        bus.sw_rst = 1'b1;
        tick("sw_in_hold");
        bus.sw_rst = 1'b0;
        tick("sw_hold");
        tick("sw_exit");
        chk("sw_exit_high",   32'(bus.sys_rst_n), 32'd1);
        chk("sw_exit_uptime", 32'(bus.uptime), 32'd0);
        for (int i = 0; i < 60; i++) begin
            bus.sw_rst = ($urandom_range(0, 9) == 0);
            tick("sw_rand");
        end
        bus.sw_rst = 1'b0;
        repeat (6) tick("sw_settle");

        // 3. Key: a short glitch is ignored, a long press resets, release restarts.
        bus.key_n = 1'b0;
        repeat (3) tick("key_glitch");
        bus.key_n = 1'b1;
        repeat (10) tick("key_glitch_after");
        chk("key_glitch_no_reset", 32'(bus.sys_rst_n), 32'd1);
        bus.key_n = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            tick("key_press");
            if (i == 6) chk("key_press_edge6", 32'(bus.sys_rst_n), 32'd1);
            if (i == 7) chk("key_press_edge7", 32'(bus.sys_rst_n), 32'd0);
        end
        chk("key_press_held", 32'(bus.sys_rst_n), 32'd0);
        bus.key_n = 1'b1;
        for (int i = 1; i <= 11; i++) begin
            tick("key_release");
            if (i == 10) chk("key_release_edge10", 32'(bus.sys_rst_n), 32'd0);
            if (i == 11) chk("key_release_edge11", 32'(bus.sys_rst_n), 32'd1);
        end
        chk("key_cause", 32'(bus.cause), 32'h1);

        // 4. Watchdog: regular kicks, starvation, and a kick on the expiry edge.
        bus.wdt_en = 1'b1;
        for (int i = 0; i < 60; i++) begin
            bus.wdt_kick = (i % 10 == 0);
            tick("wdt_kicked");
        end
        chk("wdt_kicked_no_reset", 32'(bus.sys_rst_n), 32'd1);
        bus.wdt_kick = 1'b1;
        tick("wdt_last_kick");
        bus.wdt_kick = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            tick("wdt_starve");
            if (i == 15) chk("wdt_edge15_high", 32'(bus.sys_rst_n), 32'd1);
            if (i == 16) chk("wdt_edge16_low",  32'(bus.sys_rst_n), 32'd0);
        end
        chk("wdt_cause", 32'(bus.cause), 32'h4);
        repeat (5) tick("wdt_hold");
        bus.wdt_kick = 1'b1;
        tick("wdt_kick0");
        bus.wdt_kick = 1'b0;
        repeat (15) tick("wdt_wait");
        bus.wdt_kick = 1'b1;
        tick("wdt_kick16");
        bus.wdt_kick = 1'b0;
        chk("wdt_kick16_no_reset", 32'(bus.sys_rst_n), 32'd1);
        repeat (3) tick("wdt_after");

        // 5. Software request on the same edge as a watchdog timeout.
        bus.wdt_kick = 1'b1;
        tick("sim_kick");
        bus.wdt_kick = 1'b0;
        repeat (15) tick("sim_wait");
        bus.sw_rst = 1'b1;
        tick("sim_edge");
        bus.sw_rst = 1'b0;
        chk("sim_cause", 32'(bus.cause), 32'h6);
        bus.wdt_en = 1'b0;
        repeat (6) tick("sim_settle");

        // 6. The uptime counter wraps modulo 256.
        apply_reset();
        repeat (HOLD) tick("wrap_hold");
        repeat (300) tick("wrap_run");
        chk("wrap_uptime44", 32'(bus.uptime), 32'd44);
        chk("wrap_no_reset", 32'(bus.sys_rst_n), 32'd1);

        // 7. Random mix of all sources against the model.
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 7) == 0) bus.key_n = ~bus.key_n;
            bus.sw_rst   = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 29) == 0) bus.wdt_en = ~bus.wdt_en;
            bus.wdt_kick = ($urandom_range(0, 11) == 0);
            tick("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rst_ctrl.md
# rst_ctrl

Parametrised system reset controller. It produces the core-wide `sys_rst_n` from four sources:
- the asynchronous power-on/global reset;
- a debounced pushbutton;
- a software reset request;
- a watchdog timer.

Deassertion is always synchronous and stretched to a minimum pulse width. The block also records which source caused the last reset and runs an uptime counter. It sits between the board pins and `core`, and drives the core's `rst_n` input.

## Interface
Parameters:
- SYNC_STAGES, 3: flip-flop stages on `key_n` synchroniser; minimum 2.
- DEBOUNCE_CYCLES, 50000: cycles `key` must be stable before it is accepted; minimum 1.
- HOLD_CYCLES, 16: minimum `sys_rst_n` low time after the last source releases; minimum 1.
- WDT_WIDTH, 24: watchdog counter width.
- CNT_WIDTH, 24: uptime counter width.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  asynchronous, active-low global reset. Asserts everything immediately. Its release is sampled on `clk`.
- key_n  in  1  raw pushbutton, active-low, asynchronous to `clk`.
- sw_rst  in  1  synchronous software reset request; sampled every cycle.
- wdt_en  in  1  watchdog enable level.
- wdt_kick  in  1  watchdog restart pulse.
- sys_rst_n  out  1  registered, active-low system reset.
- cause  out  3  last reset cause, bits {wdt, sw, key}; 3'b000 = power-on.
- uptime  out  CNT_WIDTH  cycles spent in RUN since the last reset.

## Operation
- **Key synchroniser:** SYNC_STAGES flops. Reset value is all ones (released). The output is `key_sync`.
- **Debounce:**
  - `key_stable` resets to 1.
  - `db_cnt` resets to 0.
  - If `key_sync == key_stable`, `db_cnt` clears to 0.
  - Otherwise `db_cnt` increments. On the edge where it would reach DEBOUNCE_CYCLES, `key_stable <= key_sync` and `db_cnt` clears.
- **State machine:** two states, HOLD and RUN. Reset state is HOLD with `hold_cnt = 0`.
  - **HOLD:**
    - `sys_rst_n = 0`; `uptime` held at 0; watchdog counter held at 0; `sw_rst` and `wdt_kick` ignored.
    - `hold_cnt` increments every cycle while `key_stable == 1`, and clears to 0 while `key_stable == 0`. A held button therefore extends the reset.
    - When `hold_cnt == HOLD_CYCLES-1` and `key_stable == 1`, the next state is RUN and `sys_rst_n` goes high on that same edge.
  - **RUN:**
    - `sys_rst_n = 1`; `uptime` increments every cycle and wraps modulo 2^CNT_WIDTH.
    - Trigger vector `trig = {wdt_to, sw_rst, ~key_stable}`.
    - If any bit of `trig` is set: next state is HOLD, `hold_cnt` clears, `cause <= trig` (all simultaneous sources recorded), `uptime` clears, and `sys_rst_n` falls on that edge.
- **Watchdog:**
  - `wdt_cnt` counts in RUN while `wdt_en == 1` and `wdt_kick == 0`.
  - It clears on `wdt_kick`, on `wdt_en == 0`, and in HOLD.
  - `wdt_to = wdt_en & ~wdt_kick & (wdt_cnt == all ones)`. A kick on the timeout cycle wins: no reset, counter clears.
- **`cause` persistence:** `cause` holds across HOLD → RUN. Only a new RUN trigger or `rst_n` changes it.
- **Reset values** (`rst_n` low, taking effect asynchronously):
  - `sys_rst_n = 0`, `cause = 3'b000`, `uptime = 0`.
  - All internal counters 0; `key_stable = 1`; synchroniser all ones; state HOLD.

## Timing
- `rst_n` assertion drives `sys_rst_n` low combinationally-free, via async clear of its register, with no clock needed.
- **After `rst_n` release:** count edge 1 as the first `clk` edge with `rst_n` high. `sys_rst_n` rises on edge HOLD_CYCLES.
- **`sw_rst`:** high at edge k in RUN → `sys_rst_n` low after edge k, `cause = 3'b010`. `sys_rst_n` high again after edge k+HOLD_CYCLES.
- **Key press:** `key_n` falls before edge 1 and stays low.
  - `key_sync` falls after edge SYNC_STAGES.
  - `key_stable` falls after edge SYNC_STAGES+DEBOUNCE_CYCLES.
  - `sys_rst_n` falls after edge SYNC_STAGES+DEBOUNCE_CYCLES+1.
- **Key release:** release is debounced with the same latency. HOLD_CYCLES is counted from the edge after `key_stable` returns to 1.
- **Bounce:** a glitch shorter than DEBOUNCE_CYCLES cycles at `key_sync` never changes `key_stable`.
- **Watchdog:** with `wdt_en` high from edge 1 and no kicks, `sys_rst_n` falls after edge 2^WDT_WIDTH, with `cause = 3'b100`.
- **`rst_n` mid-HOLD or mid-RUN:** immediate return to reset values, including `cause = 0`.

## Test plan
All scenarios use SYNC_STAGES=2, DEBOUNCE_CYCLES=4, HOLD_CYCLES=5, WDT_WIDTH=4, CNT_WIDTH=8.

1. **Power-on:** release `rst_n` → `sys_rst_n` rises after edge 5, `cause = 0`, `uptime` reads 3 after 3 further edges. Pulse `rst_n` low mid-cycle → `sys_rst_n = 0` before the next edge.
2. **Software reset:** `sw_rst` one cycle at edge k → `sys_rst_n` low from k to k+5, `cause = 3'b010`, `uptime = 0` at exit. Asserting `sw_rst` during HOLD has no effect.
3. **Key:**
   - 3-cycle low glitch on `key_n` → no reset.
   - Hold `key_n` low 20 cycles → `sys_rst_n` falls after edge 7 and stays low.
   - Release → `sys_rst_n` rises 2+4+5 edges after release; `cause = 3'b001`.
4. **Watchdog:**
   - `wdt_en` = 1 with a kick every 10 cycles → never resets.
   - Stop kicking → reset exactly 16 edges after the last kick; `cause = 3'b100`.
   - Kick on the 16th edge → no reset.
5. **Simultaneous:** `sw_rst` on the same edge as a watchdog timeout → `cause = 3'b110`.
6. **Wrap:** let `uptime` run 300 cycles → it reads 44 (300 mod 256) with no reset side effects.
